// File: rtl/period_meter.sv
// period_meter: measures the period and high time of an asynchronous strobe in clk cycles.
// top reports period-1 so it can be loaded straight into a divider to regenerate the waveform.
module period_meter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         en,
  input  logic         in,
  output logic [n-1:0] top,
  output logic [n-1:0] high,
  output logic         valid,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [n-1:0] ZERO = '0;
  localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic         r_s1;
  logic         r_s2;
  logic         r_d;
  logic [n-1:0] r_cnt;
  logic [n-1:0] r_hcnt;
  logic [n-1:0] r_top;
  logic [n-1:0] r_high;
  logic         r_valid;
  logic         r_ovf;

  logic         w_rise;
  logic         w_cntFull;
  logic [n-1:0] w_hInc;

  // Flops reset high so an input already high at reset does not look like a rising edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_d  <= 1'b1;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_d;
  assign w_cntFull = &r_cnt;
  assign w_hInc    = {{(n-1){1'b0}}, r_s2};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_cnt   <= ZERO;
      r_hcnt  <= ZERO;
      r_top   <= ZERO;
      r_high  <= ZERO;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        // Disable beats a coincident edge: results are kept, nothing is published.
        r_state <= IDLE;
        r_cnt   <= ZERO;
        r_hcnt  <= ZERO;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ARM;
            r_cnt   <= ZERO;
            r_hcnt  <= ZERO;
          end
          ARM: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= ZERO;
              r_hcnt  <= ONE;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_top   <= r_cnt;
              r_high  <= r_hcnt;
              r_valid <= 1'b1;
              r_ovf   <= 1'b0;
              r_cnt   <= ZERO;
              r_hcnt  <= ONE;
            end else if (w_cntFull) begin
              // Period longer than 2^n: flag it and re-arm on the next edge.
              r_ovf   <= 1'b1;
              r_state <= ARM;
              r_cnt   <= ZERO;
              r_hcnt  <= ZERO;
            end else begin
              r_cnt  <= r_cnt + ONE;
              r_hcnt <= r_hcnt + w_hInc;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= ZERO;
            r_hcnt  <= ZERO;
          end
        endcase
      end
    end
  end

  assign top   = r_top;
  assign high  = r_high;
  assign valid = r_valid;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed strobes against a sample-history reference model;
// expected results are queued per clock edge and a negedge monitor scores the DUT against them.
module tb_period_meter;

  localparam int N    = 8;
  localparam int MAXE = 40000;
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;

  logic         clk     = 1'b0;
  logic         n_reset = 1'b0;
  logic         en      = 1'b0;
  logic         in      = 1'b0;
  logic [N-1:0] top;
  logic [N-1:0] high;
  logic         valid;
  logic         ovf;

  int testCount = 0;
  int failCount = 0;
  int validSeen = 0;

  period_meter #(.n(N)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .en     (en),
    .in     (in),
    .top    (top),
    .high   (high),
    .valid  (valid),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edgeNo;
    bit isValid;
    int top;
    int high;
  } exp_t;

  exp_t expQ[$];
  bit   lvMem[MAXE];
  int   edgeIdx   = 0;
  int   epoch     = 0;
  int   startEdge = 0;
  int   mode      = M_IDLE;
  int   expTop    = 0;
  int   expHigh   = 0;
  int   expOvf    = 0;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned req);
    testCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeIdx, act, req);
    end
  endtask

  // Input level captured at clock edge i; everything before the last reset reads as high.
  function automatic bit lv(input int i);
    if (i < epoch || i < 0 || i >= MAXE) return 1'b1;
    return lvMem[i];
  endfunction

  task automatic resetModel();
    mode    = M_IDLE;
    epoch   = edgeIdx + 1;
    expTop  = 0;
    expHigh = 0;
    expOvf  = 0;
    expQ.delete();
  endtask

  always @(negedge n_reset) resetModel();

  // A period is the distance between two detected rising samples; high time is the
  // number of high samples in that window. Detection lags the input sample by two edges.
  always @(posedge clk) begin
    bit   rise;
    int   h;
    exp_t e;
    edgeIdx = edgeIdx + 1;
    if (!n_reset) begin
      resetModel();
    end else begin
      if (edgeIdx < MAXE) lvMem[edgeIdx] = in;
      rise = lv(edgeIdx - 2) && !lv(edgeIdx - 3);
      if (!en) begin
        mode = M_IDLE;
      end else if (mode == M_IDLE) begin
        mode = M_ARM;
      end else if (mode == M_ARM) begin
        if (rise) begin
          mode      = M_MEAS;
          startEdge = edgeIdx;
        end
      end else if (rise) begin
        h = 0;
        for (int i = startEdge - 2; i <= edgeIdx - 3; i++) h += lv(i);
        expTop    = edgeIdx - startEdge - 1;
        expHigh   = h;
        expOvf    = 0;
        e.edgeNo  = edgeIdx;
        e.isValid = 1'b1;
        e.top     = expTop;
        e.high    = expHigh;
        expQ.push_back(e);
        startEdge = edgeIdx;
      end else if (edgeIdx - startEdge == (1 << N)) begin
        expOvf    = 1;
        mode      = M_ARM;
        e.edgeNo  = edgeIdx;
        e.isValid = 1'b0;
        e.top     = expTop;
        e.high    = expHigh;
        expQ.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (n_reset) begin
      bit   expV;
      exp_t e;
      expV = (expQ.size() > 0) && (expQ[0].edgeNo == edgeIdx) && expQ[0].isValid;
      checkOutput("valid_pulse", valid, expV);
      if (valid) validSeen++;
      if (expV) begin
        e = expQ.pop_front();
        checkOutput("valid_top", top, e.top);
        checkOutput("valid_high", high, e.high);
        checkOutput("valid_ovf", ovf, 0);
      end
      while (expQ.size() > 0 && expQ[0].edgeNo <= edgeIdx) begin
        e = expQ.pop_front();
        if (!e.isValid) begin
          checkOutput("ovf_top_hold", top, e.top);
          checkOutput("ovf_high_hold", high, e.high);
        end
      end
      checkOutput("ovf_flag", ovf, expOvf);
    end
  end

  // Periodic strobe starting high; en drops for three cycles from dropAt when dropAt >= 0.
  task automatic applyStimulus(input int period, input int hi, input int cycles, input int dropAt);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      in = ((c % period) < hi);
      en = !(dropAt >= 0 && c >= dropAt && c < dropAt + 3);
    end
  endtask

  task automatic checkResult(input string tag, input int t, input int h, input int o);
    checkOutput({tag, "_top"}, top, t);
    checkOutput({tag, "_high"}, high, h);
    checkOutput({tag, "_ovf"}, ovf, o);
  endtask

  initial begin
    int divT[3];
    int p, hi, cyc, drop;
    divT[0] = 5;
    divT[1] = 12;
    divT[2] = 31;

    repeat (3) @(negedge clk);
    checkResult("reset", 0, 0, 0);
    checkOutput("reset_valid", valid, 0);
    n_reset = 1'b1;

    for (int k = 0; k < 3; k++)
      applyStimulus(divT[k] + 1, divT[k] - (divT[k] >> 1), 10 * (divT[k] + 1), -1);
    checkResult("divider", 31, 16, 0);

    applyStimulus(2, 1, 20, -1);
    checkResult("min_period", 1, 1, 0);

    applyStimulus(256, 1, 768, -1);
    checkResult("max_period", 255, 1, 0);

    applyStimulus(300, 1, 700, -1);
    checkResult("overflow", 255, 1, 1);

    applyStimulus(10, 5, 50, -1);
    checkResult("recovery", 9, 5, 0);

    applyStimulus(8, 4, 48, -1);
    checkResult("pre_drop", 7, 4, 0);
    applyStimulus(8, 4, 3, 0);
    checkResult("en_drop", 7, 4, 0);
    applyStimulus(8, 4, 45, -1);
    checkResult("after_drop", 7, 4, 0);

    applyStimulus(8, 2, 40, -1);
    checkResult("duty_low", 7, 2, 0);
    applyStimulus(8, 6, 40, -1);
    checkResult("duty_high", 7, 6, 0);

    for (int k = 0; k < 25; k++) begin
      p    = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 262) : $urandom_range(2, 40);
      hi   = $urandom_range(1, p - 1);
      cyc  = p * $urandom_range(3, 5);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cyc - 1) : -1;
      applyStimulus(p, hi, cyc, drop);
    end

    applyStimulus(20, 7, 60, -1);
    checkResult("pre_reset", 19, 7, 0);
    @(posedge clk);
    #3 n_reset = 1'b0;
    #1;
    checkResult("async_reset", 0, 0, 0);
    checkOutput("async_reset_valid", valid, 0);
    @(negedge clk);
    in = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    n_reset   = 1'b1;
    validSeen = 0;
    repeat (30) @(negedge clk);
    #1;
    checkOutput("no_false_valid", validSeen, 0);
    checkResult("held_high", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures an incoming periodic signal and reports its period and high time in clock cycles, as one-cycle-validated samples. It is the receiving counterpart of the divided-clock counter. Its `top` output is the value that, loaded into a counter, regenerates the same period, so the pair can be used for loop-back checks, APU/PPU timing calibration, and frequency tracking of external strobes.

## Interface
Parameters:
- `n`, default 8: measurement counter width; the maximum measurable period is 2^n cycles.

Ports:
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: measurement enable. When low, the block idles.
- `in`, in, 1: signal to measure. It is asynchronous to `clk` and is synchronised internally.
- `top`, out, n: last measured period minus 1, in cycles.
- `high`, out, n: cycles `in` was high within that period.
- `valid`, out, 1: one-cycle pulse when `top`/`high` update.
- `ovf`, out, 1: sticky flag; the last attempted period exceeded 2^n cycles.

## Operation
- **Synchronisation and edge detect**
  - `in` passes through a 2-flop synchroniser (`s1`, `s2`), then a delay flop `d`.
  - `s1`, `s2` and `d` reset to 1, so an input that is high at reset creates no false edge.
  - `rise = s2 & ~d`.
  - All further logic uses `s2` only.
- **States**
  - IDLE: counters held at 0. Go to ARM when `en`=1.
  - ARM: wait for the reference edge. On `rise`, go to MEASURE with `cnt`=0 and `hcnt`=1.
  - MEASURE, cycles without `rise`:
    - `cnt` += 1.
    - `hcnt` += 1 if `s2`=1.
  - MEASURE, cycle with `rise`:
    - `top` <= `cnt`, `high` <= `hcnt`, `valid` <= 1, `ovf` <= 0.
    - Restart with `cnt`=0 and `hcnt`=1; stay in MEASURE.
  - MEASURE, overflow: `cnt` = all-ones and no `rise` in that cycle.
    - Set `ovf` <= 1, no `valid`, go to ARM.
    - `top`/`high` keep their previous values.
  - Any state, `en`=0: go to IDLE next cycle.
    - `top`, `high` and `ovf` are retained.
    - No `valid` is issued, even if `rise` occurs in the same cycle.
- **Arithmetic**
  - `cnt` and `hcnt` are n bits, unsigned.
  - `hcnt` cannot exceed P−1, because a rising edge requires at least one low cycle, so it never wraps.
  - `cnt` never wraps: the overflow rule fires first.
- **Period mapping:** for a period-P input (2 ≤ P ≤ 2^n), `top` = P−1 and `high` = number of high cycles per period.
  - A counter-divider with top T outputs period T+1, high for T − (T>>1) cycles.
  - The meter fed from it must report `top`=T and `high`=T−(T>>1).
- **Minimum resolvable:** period 2 cycles. Slower-changing inputs are exact to ±0 cycles once stable, because edges are quantised to `clk`.

## Timing
- **Reset values:** state IDLE, `top`=0, `high`=0, `valid`=0, `ovf`=0, `cnt`=0, `hcnt`=0, `s1`=`s2`=`d`=1.
- **Latency:** an `in` rise set up before clock edge k appears in `s1` at k, `s2` at k+1, and `rise` is true in the cycle after edge k+1. `valid`/`top`/`high` update at edge k+2.
- **Valid pulse:** `valid` is high for exactly one cycle per accepted rising edge. The first valid occurs at the second rising edge after entering ARM.
- **Overflow timing:** `ovf` rises on the edge where `cnt` would reach 2^n. It stays high until the next `valid` or reset.
- **Simultaneous events:**
  - `rise` with `cnt` = all-ones gives a valid measurement (P = 2^n), not overflow.
  - `en`=0 with `rise`: `en` wins.
- **Reset mid-measurement:** all state is cleared asynchronously. Measurement restarts via ARM once `n_reset` deasserts and `en`=1.

## Test plan
- **Reset state:** assert `n_reset`=0 mid-MEASURE → all outputs 0 immediately. After release with `in` held high, no `valid` appears.
- **Divider loop-back:** n=8, `in` driven by a divider with T=5 (period 6, high 3) → first `valid` after 2 rises, then every 6 cycles, each with `top`=5 and `high`=3, `ovf`=0.
- **Minimum and maximum period:**
  - `in` toggling every cycle → `top`=1, `high`=1.
  - Period 256 with 1-cycle high → `top`=255, `high`=1, no `ovf`.
- **Overflow then recovery:** period 300 at n=8 → `ovf`=1 at cycle 256 after the edge, with no `valid` and `top` unchanged. Switching to period 10 → next valid has `top`=9 and `ovf` returns to 0.
- **Enable drop:** `en`=0 for 3 cycles mid-MEASURE, coincident with a rise → no `valid`, `top`/`high` retained. After `en`=1 the first `valid` needs two further rises.
- **Duty change:** switch `in` from 2/8 high to 6/8 high → consecutive valids report `high`=2, then `high`=6, with `top`=7 throughout.
